// File: rtl/spec_level_tracker.sv
// rtl/spec_level_tracker.sv - branch speculation level tracker and br_pred broadcaster
//
// Purpose:
//   Assigns a speculation level to each dispatched instruction. A predicted
//   branch opens a new level and its tag is recorded against that level.
//   Branch resolutions are matched against the recorded tags. A hit raises
//   one pending broadcast on the br_pred_* handshake: either a succ remap
//   vector or a fail level. A miss is dropped, because that branch was
//   already squashed.
//
// Optional feature:
//   SPEC_TRACKER_STATS_EN - adds saturating 16-bit succ/fail/drop counters.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   disp_vld_i / disp_rdy_o    dispatch handshake
//   disp_is_br_i, disp_id_i    dispatched instruction is a branch, and its tag
//   disp_spec_level_o          level written into the station with the instruction
//   res_vld_i / res_rdy_o      resolution handshake
//   res_id_i, res_succ_i       tag of the resolved branch, and prediction-correct flag
//   br_pred_vld_o / _rdy_i     broadcast handshake to all issue stations
//   br_pred_succ_o             broadcast type (1 = succ remap, 0 = fail squash)
//   br_pred_fail_level_o       first squashed level, or the level being retired
//   br_pred_succ_nxt_levels_o  entry k = new level for old level k
//   cur_level_o, full_o        current open level, and open level == SPEC_DEPTH
//   stat_*_cnt_o               event counters (SPEC_TRACKER_STATS_EN only)

module spec_level_tracker #(
  parameter int SPEC_DEPTH     = 4,
  parameter int INST_ID_BIT    = 8,
  parameter int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     disp_vld_i,
  output logic                                     disp_rdy_o,
  input  logic                                     disp_is_br_i,
  input  logic [INST_ID_BIT-1:0]                   disp_id_i,
  output logic [SPEC_LEVEL_BIT-1:0]                disp_spec_level_o,
  input  logic                                     res_vld_i,
  output logic                                     res_rdy_o,
  input  logic [INST_ID_BIT-1:0]                   res_id_i,
  input  logic                                     res_succ_i,
  output logic                                     br_pred_vld_o,
  input  logic                                     br_pred_rdy_i,
  output logic                                     br_pred_succ_o,
  output logic [SPEC_LEVEL_BIT-1:0]                br_pred_fail_level_o,
  output logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0] br_pred_succ_nxt_levels_o,
  output logic [SPEC_LEVEL_BIT-1:0]                cur_level_o,
  output logic                                     full_o
`ifdef SPEC_TRACKER_STATS_EN
  ,
  output logic [15:0]                              stat_succ_cnt_o,
  output logic [15:0]                              stat_fail_cnt_o,
  output logic [15:0]                              stat_drop_cnt_o
`endif
);

  localparam logic [SPEC_LEVEL_BIT-1:0] LVL_MAX = SPEC_LEVEL_BIT'(SPEC_DEPTH);

  logic [SPEC_LEVEL_BIT-1:0] cur_level_q, cur_level_d;
  logic [INST_ID_BIT-1:0]    br_ids_q [1:SPEC_DEPTH];
  logic [INST_ID_BIT-1:0]    br_ids_d [1:SPEC_DEPTH];
  logic                      pend_vld_q, pend_vld_d;
  logic                      pend_succ_q, pend_succ_d;
  logic [SPEC_LEVEL_BIT-1:0] pend_level_q, pend_level_d;

  logic                      bcast_fire, succ_fire, fail_fire;
  logic                      disp_fire, res_fire;
  logic                      cam_hit;
  logic [SPEC_LEVEL_BIT-1:0] cam_level;
  logic [SPEC_LEVEL_BIT-1:0] eff_level;

  assign bcast_fire = pend_vld_q && br_pred_rdy_i;
  assign succ_fire  = bcast_fire && pend_succ_q;
  assign fail_fire  = bcast_fire && !pend_succ_q;

  // A retiring succ level frees one slot in this same cycle, so dispatch sees the post-shift level.
  assign eff_level  = succ_fire ? cur_level_q - SPEC_LEVEL_BIT'(1) : cur_level_q;

  assign disp_rdy_o = !(pend_vld_q && !pend_succ_q) && !(disp_is_br_i && eff_level == LVL_MAX);
  assign disp_fire  = disp_vld_i && disp_rdy_o;
  assign disp_spec_level_o = eff_level;

  // The pending register is the only resolution buffer, so a new resolution waits for it to drain.
  assign res_rdy_o  = !pend_vld_q;
  assign res_fire   = res_vld_i && res_rdy_o;

  assign br_pred_vld_o        = pend_vld_q;
  assign br_pred_succ_o       = pend_succ_q;
  assign br_pred_fail_level_o = pend_level_q;
  assign cur_level_o          = cur_level_q;
  assign full_o               = (cur_level_q == LVL_MAX);

  // Tag match over the valid entries. The scan runs downward so the lowest matching level wins.
  always_comb begin
    cam_hit   = 1'b0;
    cam_level = '0;
    for (int k = SPEC_DEPTH; k >= 1; k--) begin
      if (SPEC_LEVEL_BIT'(k) <= cur_level_q && br_ids_q[k] == res_id_i) begin
        cam_hit   = 1'b1;
        cam_level = SPEC_LEVEL_BIT'(k);
      end
    end
  end

  // Levels at or above L move down by one. pend_level_q is 0 only out of reset, and that keeps the identity map.
  always_comb begin
    br_pred_succ_nxt_levels_o = '0;
    for (int k = 0; k <= SPEC_DEPTH; k++) begin
      if (pend_level_q != '0 && SPEC_LEVEL_BIT'(k) >= pend_level_q)
        br_pred_succ_nxt_levels_o[k*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT] = SPEC_LEVEL_BIT'(k - 1);
      else
        br_pred_succ_nxt_levels_o[k*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT] = SPEC_LEVEL_BIT'(k);
    end
  end

  always_comb begin
    cur_level_d  = cur_level_q;
    br_ids_d     = br_ids_q;
    pend_vld_d   = pend_vld_q;
    pend_succ_d  = pend_succ_q;
    pend_level_d = pend_level_q;

    if (bcast_fire) pend_vld_d = 1'b0;

    if (succ_fire) begin
      for (int k = 1; k < SPEC_DEPTH; k++) begin
        if (SPEC_LEVEL_BIT'(k) >= pend_level_q) br_ids_d[k] = br_ids_q[k+1];
      end
      cur_level_d = cur_level_q - SPEC_LEVEL_BIT'(1);
    end else if (fail_fire) begin
      // Entries above the new level are invalid, because validity is defined by cur_level.
      cur_level_d = pend_level_q - SPEC_LEVEL_BIT'(1);
    end

    // The branch write lands after the succ shift, at the slot just above its own level.
    if (disp_fire && disp_is_br_i) begin
      for (int k = 1; k <= SPEC_DEPTH; k++) begin
        if (SPEC_LEVEL_BIT'(k) == eff_level + SPEC_LEVEL_BIT'(1)) br_ids_d[k] = disp_id_i;
      end
      cur_level_d = eff_level + SPEC_LEVEL_BIT'(1);
    end

    if (res_fire && cam_hit) begin
      pend_vld_d   = 1'b1;
      pend_succ_d  = res_succ_i;
      pend_level_d = cam_level;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_level_q  <= '0;
      pend_vld_q   <= 1'b0;
      pend_succ_q  <= 1'b0;
      pend_level_q <= '0;
      for (int k = 1; k <= SPEC_DEPTH; k++) br_ids_q[k] <= '0;
    end else begin
      cur_level_q  <= cur_level_d;
      pend_vld_q   <= pend_vld_d;
      pend_succ_q  <= pend_succ_d;
      pend_level_q <= pend_level_d;
      br_ids_q     <= br_ids_d;
    end
  end

`ifdef SPEC_TRACKER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_succ_cnt_o <= '0;
      stat_fail_cnt_o <= '0;
      stat_drop_cnt_o <= '0;
    end else begin
      if (succ_fire && stat_succ_cnt_o != 16'hFFFF) stat_succ_cnt_o <= stat_succ_cnt_o + 16'd1;
      if (fail_fire && stat_fail_cnt_o != 16'hFFFF) stat_fail_cnt_o <= stat_fail_cnt_o + 16'd1;
      if (res_fire && !cam_hit && stat_drop_cnt_o != 16'hFFFF)
        stat_drop_cnt_o <= stat_drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spec_level_tracker.sv
// tb/tb_spec_level_tracker.sv - testbench for spec_level_tracker
module tb_spec_level_tracker;
  localparam int D = 4;
  localparam int IB = 8;
  localparam int W = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic disp_vld, disp_rdy, disp_is_br;
  logic [IB-1:0] disp_id;
  logic [W-1:0] disp_spec_level;
  logic res_vld, res_rdy, res_succ;
  logic [IB-1:0] res_id;
  logic br_pred_vld, br_pred_rdy, br_pred_succ;
  logic [W-1:0] br_pred_fail_level, cur_level;
  logic [W*(D+1)-1:0] nxt_levels;
  logic full;
`ifdef SPEC_TRACKER_STATS_EN
  logic [15:0] stat_succ, stat_fail, stat_drop;
`endif

  always #5 clk = ~clk;

  spec_level_tracker #(.SPEC_DEPTH(D), .INST_ID_BIT(IB)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_vld_i(disp_vld), .disp_rdy_o(disp_rdy), .disp_is_br_i(disp_is_br),
    .disp_id_i(disp_id), .disp_spec_level_o(disp_spec_level),
    .res_vld_i(res_vld), .res_rdy_o(res_rdy), .res_id_i(res_id), .res_succ_i(res_succ),
    .br_pred_vld_o(br_pred_vld), .br_pred_rdy_i(br_pred_rdy), .br_pred_succ_o(br_pred_succ),
    .br_pred_fail_level_o(br_pred_fail_level), .br_pred_succ_nxt_levels_o(nxt_levels),
    .cur_level_o(cur_level), .full_o(full)
`ifdef SPEC_TRACKER_STATS_EN
    , .stat_succ_cnt_o(stat_succ), .stat_fail_cnt_o(stat_fail), .stat_drop_cnt_o(stat_drop)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: m_ids[i] is the tag of the branch that opened level i+1.
  int m_ids[$];
  bit m_pvld, m_psucc;
  int m_plevel;
  int m_succ_n, m_fail_n, m_drop_n;
  int tag_ctr = 'h40;

  // Last sampled DUT outputs, for the hand-computed expectations.
  bit s_disp_rdy, s_res_rdy, s_vld, s_succ;
  int s_lvl, s_fail_lvl, s_cur, s_nxt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ids.delete();
    m_pvld = 0; m_psucc = 0; m_plevel = 0;
    m_succ_n = 0; m_fail_n = 0; m_drop_n = 0;
  endtask

  // Drives one cycle of inputs, checks every output at the falling edge, then advances the model.
  task automatic step(input bit dv, input bit db, input int did, input bit rv,
                      input int rid, input bit rs, input bit pr);
    bit succ_fire, bfire, e_drdy, e_rrdy;
    int e_lvl, hit;
    logic [W*(D+1)-1:0] e_nxt;
    disp_vld = dv; disp_is_br = db; disp_id = IB'(did);
    res_vld = rv; res_id = IB'(rid); res_succ = rs; br_pred_rdy = pr;
    @(negedge clk);
    bfire = m_pvld && pr;
    succ_fire = bfire && m_psucc;
    e_lvl = m_ids.size() - (succ_fire ? 1 : 0);
    e_drdy = !(m_pvld && !m_psucc) && !(db && e_lvl == D);
    e_rrdy = !m_pvld;
    e_nxt = '0;
    for (int k = 0; k <= D; k++)
      e_nxt[k*W +: W] = W'((m_plevel > 0 && k >= m_plevel) ? k - 1 : k);
    chk("disp_rdy", int'(disp_rdy), int'(e_drdy));
    chk("disp_spec_level", int'(disp_spec_level), e_lvl);
    chk("res_rdy", int'(res_rdy), int'(e_rrdy));
    chk("br_pred_vld", int'(br_pred_vld), int'(m_pvld));
    chk("cur_level", int'(cur_level), m_ids.size());
    chk("full", int'(full), int'(m_ids.size() == D));
    if (m_pvld) begin
      chk("br_pred_succ", int'(br_pred_succ), int'(m_psucc));
      chk("br_pred_fail_level", int'(br_pred_fail_level), m_plevel);
      chk("nxt_levels", int'(nxt_levels), int'(e_nxt));
    end
    s_disp_rdy = disp_rdy; s_res_rdy = res_rdy; s_vld = br_pred_vld; s_succ = br_pred_succ;
    s_lvl = int'(disp_spec_level); s_fail_lvl = int'(br_pred_fail_level);
    s_cur = int'(cur_level); s_nxt = int'(nxt_levels);
    if (bfire) begin
      if (m_psucc) begin
        m_ids.delete(m_plevel - 1);
        m_succ_n++;
      end else begin
        while (m_ids.size() >= m_plevel) void'(m_ids.pop_back());
        m_fail_n++;
      end
      m_pvld = 0;
    end
    if (dv && e_drdy && db) m_ids.push_back(did & 'hFF);
    if (rv && e_rrdy) begin
      hit = -1;
      foreach (m_ids[i]) if (hit < 0 && m_ids[i] == (rid & 'hFF)) hit = i;
      if (hit >= 0) begin
        m_pvld = 1; m_psucc = rs; m_plevel = hit + 1;
      end else m_drop_n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit pr);
    step(0, 0, 0, 0, 0, 0, pr);
  endtask

  initial begin
    int rid;
    model_reset();
    disp_vld = 0; disp_is_br = 0; disp_id = '0;
    res_vld = 0; res_id = '0; res_succ = 0; br_pred_rdy = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    idle(0);
    chk("rst_disp_rdy", int'(s_disp_rdy), 1);
    chk("rst_res_rdy", int'(s_res_rdy), 1);
    chk("rst_lvl", s_lvl, 0);
    chk("rst_nxt", s_nxt, int'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));

    step(1, 1, 'h10, 0, 0, 0, 1); chk("lvl_b10", s_lvl, 0);
    step(1, 1, 'h11, 0, 0, 0, 1); chk("lvl_b11", s_lvl, 1);
    step(1, 1, 'h12, 0, 0, 0, 1); chk("lvl_b12", s_lvl, 2);
    idle(1); chk("cur_3", s_cur, 3);

    step(0, 0, 0, 1, 'h11, 1, 0);
    idle(1);
    chk("succ_vld", int'(s_vld), 1);
    chk("succ_type", int'(s_succ), 1);
    chk("succ_nxt", s_nxt, int'({3'd3, 3'd2, 3'd1, 3'd1, 3'd0}));
    idle(1);
    chk("cur_after_succ", s_cur, 2);
    chk("model_id2", m_ids[1], 'h12);

    step(0, 0, 0, 1, 'h10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 'h12, 0, 0);
      chk("fail_lvl_held", s_fail_lvl, 1);
      chk("fail_disp_blk", int'(s_disp_rdy), 0);
      chk("fail_res_blk", int'(s_res_rdy), 0);
    end
    idle(1);
    idle(1); chk("cur_after_fail", s_cur, 0);
    step(0, 0, 0, 1, 'h12, 1, 1);
    idle(1); chk("miss_no_bcast", int'(s_vld), 0);

    for (int i = 0; i < 4; i++) step(1, 1, 'h20 + i, 0, 0, 0, 1);
    step(1, 1, 'h24, 0, 0, 0, 0); chk("full_br_blk", int'(s_disp_rdy), 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("full_nb_rdy", int'(s_disp_rdy), 1);
    chk("full_nb_lvl", s_lvl, 4);
    step(0, 0, 0, 1, 'h21, 1, 0);
    step(1, 1, 'h24, 0, 0, 0, 1);
    chk("full_succ_br_rdy", int'(s_disp_rdy), 1);
    chk("full_succ_br_lvl", s_lvl, 3);
    step(0, 0, 0, 1, 'h23, 0, 0);
    idle(1);
    idle(1); chk("cur_2", s_cur, 2);
    step(0, 0, 0, 1, 'h20, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1); chk("succ_nb_lvl", s_lvl, 1);

    step(0, 0, 0, 1, 'h22, 1, 0);
    idle(0);
    chk("pre_rst_vld", int'(s_vld), 1);
    rst_n = 0;
    #1;
    chk("rst_mid_vld", int'(br_pred_vld), 0);
    chk("rst_mid_cur", int'(cur_level), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 3000; n++) begin
      if (m_ids.size() > 0 && $urandom_range(0, 3) != 0)
        rid = m_ids[$urandom_range(0, m_ids.size() - 1)];
      else rid = (tag_ctr - 1 - $urandom_range(0, 7)) & 'hFF;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, tag_ctr & 'hFF,
           $urandom_range(0, 1) == 1, rid, $urandom_range(0, 9) < 7,
           $urandom_range(0, 3) != 0);
      tag_ctr++;
    end

`ifdef SPEC_TRACKER_STATS_EN
    chk("stat_succ", int'(stat_succ), m_succ_n);
    chk("stat_fail", int'(stat_fail), m_fail_n);
    chk("stat_drop", int'(stat_drop), m_drop_n);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spec_level_tracker.md
# spec_level_tracker

Producer side of the branch-speculation broadcast consumed by the issue stations. It assigns spec levels to dispatched instructions and records which branch opened each level. It matches branch resolutions from the branch FU against that record, then drives the `br_pred_*` handshake (succ remap vector or fail level) to all stations. Sits between dispatch and the issue stations.

## Interface
- `SPEC_DEPTH`, 4, max outstanding unresolved branches
- `INST_ID_BIT`, 8, instruction/branch tag width
- `SPEC_LEVEL_BIT`, `$clog2(SPEC_DEPTH)+1`, spec level width; level 0 = non-speculative
- `clk` in 1, clock
- `rst_n` in 1, reset, asynchronous, active-low
- `disp_vld` in 1, dispatch instruction valid
- `disp_rdy` out 1, tracker accepts dispatch
- `disp_is_br` in 1, dispatched instruction is a predicted branch
- `disp_id` in INST_ID_BIT, dispatched instruction tag
- `disp_spec_level` out SPEC_LEVEL_BIT, level to write into the station with this instruction
- `res_vld` in 1, branch resolution valid
- `res_rdy` out 1, resolution accepted
- `res_id` in INST_ID_BIT, tag of the resolved branch
- `res_succ` in 1, 1 = prediction correct
- `br_pred_vld` out 1, broadcast valid
- `br_pred_rdy` in 1, all stations ready (AND of station `br_pred_rdy`)
- `br_pred_succ` out 1, broadcast type
- `br_pred_fail_level` out SPEC_LEVEL_BIT, first squashed level
- `br_pred_succ_nxt_levels` out SPEC_LEVEL_BIT*(SPEC_DEPTH+1), entry k at `[k*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT]` = new level for old level k
- `cur_level` out SPEC_LEVEL_BIT, current open level
- `full` out 1, `cur_level == SPEC_DEPTH`

## Operation
- State:
  - `cur_level` (0..SPEC_DEPTH)
  - tag table `br_ids[1..SPEC_DEPTH]`; entry k = tag of the branch that opened level k, valid iff k ≤ `cur_level`
  - one pending-broadcast register: `pend_vld`, `pend_succ`, `pend_level` L
- Dispatch fire = `disp_vld && disp_rdy`.
  - `disp_spec_level` = effective level E: `cur_level`, or `cur_level-1` when a succ broadcast fires this cycle.
  - A branch itself gets level E. It opens level E+1: `br_ids[E+1] <= disp_id`, `cur_level <= E+1`.
- `disp_rdy = !(pend_vld && !pend_succ) && !(disp_is_br && E == SPEC_DEPTH)`.
  - Non-branches are accepted at full.
  - Dispatch is blocked while a fail broadcast is pending.
- Resolution:
  - `res_rdy = !pend_vld`; no bypass, so at most one resolution per two cycles.
  - On fire, CAM `res_id` against valid entries.
    - Hit at k: `pend_vld<=1`, `pend_level<=k`, `pend_succ<=res_succ`.
    - Miss (branch already squashed): resolution consumed, nothing broadcast.
- Broadcast:
  - `br_pred_vld = pend_vld`, `br_pred_fail_level = L`, `br_pred_succ = pend_succ`.
  - `nxt[k] = k` for k < L; `nxt[k] = k-1` for k ≥ L; `nxt[0] = 0`.
  - Outputs are held stable until `br_pred_rdy`.
- Broadcast fire (`br_pred_vld && br_pred_rdy`), `pend_vld<=0`, and:
  - succ: delete entry L, shift entries L+1..cur to L..cur-1, `cur_level -= 1`.
  - fail: `cur_level <= L-1`; entries ≥ L become invalid.
- Same-cycle succ fire and branch dispatch: the shift is applied first, then the write at E+1.

## Timing
- Reset values: `cur_level=0`, `pend_vld=0`, so `br_pred_vld=0`, `full=0`, `res_rdy=1`, `disp_rdy=1`, `disp_spec_level=0`. `br_pred_succ=0`, `br_pred_fail_level=0`; `nxt[k]=k`.
- Resolution to `br_pred_vld`: 1 cycle.
- `br_pred_vld` to table update: same edge as handshake.
- `disp_spec_level` is combinational from state and the succ fire; it is valid in the dispatch cycle.
- Reset mid-broadcast drops the pending broadcast.
- Back-pressure on `br_pred_rdy` keeps `res_rdy` low.

## Configuration
- `SPEC_TRACKER_STATS_EN` defined:
  - adds outputs `stat_succ_cnt`, `stat_fail_cnt`, `stat_drop_cnt` (16-bit, saturating at 0xFFFF, reset 0)
  - counts succ fires, fail fires, and CAM misses
- Undefined: ports and counters are absent; behaviour otherwise identical.

## Test plan
- Dispatch branches tags 0x10, 0x11, 0x12 -> `disp_spec_level` 0,1,2; `cur_level=3`.
- From that state, resolve 0x11 succ -> next cycle `br_pred_vld=1`, `succ=1`, `nxt={0,1,1,2,3}`. After handshake `cur_level=2`, `br_ids[2]=0x12`.
- Resolve 0x10 fail with `br_pred_rdy=0` for 3 cycles -> `fail_level=1` held; `disp_rdy=0`, `res_rdy=0`. After handshake `cur_level=0`. Later resolve 0x12 -> miss, no broadcast.
- Fill to `SPEC_DEPTH=4` -> branch dispatch has `disp_rdy=0`, non-branch has `disp_rdy=1` at level 4. Succ fire in the same cycle -> branch accepted with `disp_spec_level=3`.
- Same-cycle succ fire at L=1 (`cur_level=2`) and non-branch dispatch -> `disp_spec_level=1`.
- Assert `rst_n` while `pend_vld=1` -> `br_pred_vld=0` immediately and `cur_level=0`.
